// File: rtl/ifu_align_pkg.sv
// Shared types and helpers for the instruction aligner.
//   parcel_t      : one buffered 16-bit parcel plus its fetch-error flag
//   calc_ptr_w    : buffer pointer width for a given depth
//   calc_cnt_w    : buffer occupancy width for a given depth (holds 0..depth)
//   is_compressed : true when the low opcode bits mark a 16-bit encoding
package ifu_align_pkg;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } parcel_t;

    function automatic int unsigned calc_ptr_w(int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned calc_cnt_w(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic is_compressed(logic [1:0] op);
        return op != 2'b11;
    endfunction

endpackage

// File: rtl/ifu_inst_align_if.sv
// Fetch-return and instruction-output handshake bundle of the aligner.
//   fetch_* : 32-bit fetch words in (valid/ready), PC[31:1], access fault
//   inst_*  : aligned instruction out (valid/ready), raw bits, head parcel,
//             compressed flag, PC[31:1], error flag
// master = the aligner, slave = fetch unit / expander side.
interface ifu_inst_align_if;

    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [30:0] fetch_pc;
    logic        fetch_err;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_raw;
    logic [15:0] inst_c16;
    logic        inst_is_c;
    logic [30:0] inst_pc;
    logic        inst_err;

    modport master (
        input  fetch_valid, fetch_data, fetch_pc, fetch_err, inst_ready,
        output fetch_ready, inst_valid, inst_raw, inst_c16, inst_is_c, inst_pc, inst_err
    );

    modport slave (
        output fetch_valid, fetch_data, fetch_pc, fetch_err, inst_ready,
        input  fetch_ready, inst_valid, inst_raw, inst_c16, inst_is_c, inst_pc, inst_err
    );

endinterface

// File: rtl/ifu_parcel_buf.sv
// Circular parcel buffer: 0/1/2 parcels pushed and 0/1/2 popped per cycle.
//   clk, rst    : clock, async active-high reset
//   flush_i     : empties the buffer and rewinds both pointers to 0
//   push_cnt_i  : parcels to write this cycle (push0_i first, then push1_i)
//   pop_cnt_i   : parcels to retire from the head this cycle
//   head_o      : entry at the read pointer
//   next_o      : entry after the read pointer
//   count_o     : occupancy, 0..DEPTH
// Callers must not overfill or over-drain; full/empty is tracked by count only.
module ifu_parcel_buf
    import ifu_align_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = calc_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [1:0]       push_cnt_i,
    input  parcel_t          push0_i,
    input  parcel_t          push1_i,
    input  logic [1:0]       pop_cnt_i,
    output parcel_t          head_o,
    output parcel_t          next_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = calc_ptr_w(DEPTH);

    parcel_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W-1:0] rd_nxt, wr_nxt;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer widths equal log2(DEPTH), so the adds wrap modulo DEPTH.
    assign rd_nxt = rd_q + PTR_W'(1);
    assign wr_nxt = wr_q + PTR_W'(1);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            wr_d    = wr_q + PTR_W'(push_cnt_i);
            rd_d    = rd_q + PTR_W'(pop_cnt_i);
            count_d = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_cnt_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush_i) begin
            if (push_cnt_i != 2'd0) begin
                mem_q[wr_q] <= push0_i;
            end
            if (push_cnt_i == 2'd2) begin
                mem_q[wr_nxt] <= push1_i;
            end
        end
    end

    assign head_o  = mem_q[rd_q];
    assign next_o  = mem_q[rd_nxt];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_inst_align.sv
// Instruction aligner: turns 32-bit fetch words into whole 16/32-bit
// instructions with their PC, for the compressed-instruction expander.
//   clk, rst : clock, async active-high reset
//   flush    : redirect; drops every buffered parcel, blocks push and pop
//   io       : fetch word in / aligned instruction out (see ifu_inst_align_if)
// All instruction outputs are combinational from buffer state and head_pc.
module ifu_inst_align
    import ifu_align_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    ifu_inst_align_if.master  io
);

    localparam int unsigned CNT_W = calc_cnt_w(DEPTH);

    parcel_t          head, next;
    logic [CNT_W-1:0] count;
    logic [30:0]      head_pc_q, head_pc_d;

    logic       fetch_ready, push, head_c, size2, has_head, has_next;
    logic       complete, inst_valid, pop;
    logic [1:0] push_cnt, pop_cnt;
    parcel_t    push0, push1;

    // Conservative: a pop in the same cycle is not credited.
    assign fetch_ready = (count <= CNT_W'(DEPTH - 2)) && !flush;
    assign push        = io.fetch_valid && fetch_ready;

    // fetch_pc[0] is PC[1]: set means parcel0 lies before the target and is dropped.
    assign push_cnt = !push ? 2'd0 : (io.fetch_pc[0] ? 2'd1 : 2'd2);
    assign push0    = io.fetch_pc[0] ? parcel_t'{io.fetch_err, io.fetch_data[31:16]}
                                     : parcel_t'{io.fetch_err, io.fetch_data[15:0]};
    assign push1    = parcel_t'{io.fetch_err, io.fetch_data[31:16]};

    assign has_head = count != '0;
    assign has_next = count >= CNT_W'(2);
    assign head_c   = is_compressed(head.data[1:0]);
    // A faulting head parcel is retired alone; its partner is never inspected.
    assign size2    = !head.err && !head_c;
    assign complete = size2 ? has_next : has_head;

    assign inst_valid = complete && !flush;
    assign pop        = inst_valid && io.inst_ready;
    assign pop_cnt    = !pop ? 2'd0 : (size2 ? 2'd2 : 2'd1);

    ifu_parcel_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_cnt_i (push_cnt),
        .push0_i    (push0),
        .push1_i    (push1),
        .pop_cnt_i  (pop_cnt),
        .head_o     (head),
        .next_o     (next),
        .count_o    (count)
    );

    // Push with an empty buffer cannot coincide with a pop, so the cases are exclusive.
    always_comb begin
        head_pc_d = head_pc_q;
        if (push && !has_head) begin
            head_pc_d = io.fetch_pc;
        end else if (pop) begin
            head_pc_d = head_pc_q + 31'(pop_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_pc_q <= '0;
        end else begin
            head_pc_q <= head_pc_d;
        end
    end

    // Data outputs are masked while empty so stale entries never leak out.
    always_comb begin
        io.fetch_ready = fetch_ready;
        io.inst_valid  = inst_valid;
        io.inst_pc     = head_pc_q;
        io.inst_is_c   = has_head && head_c;
        io.inst_c16    = has_head ? head.data : 16'h0;
        io.inst_err    = has_head && (head.err || (size2 && has_next && next.err));
        io.inst_raw    = 32'h0;
        if (has_head) begin
            if (size2) begin
                io.inst_raw = {(has_next ? next.data : 16'h0), head.data};
            end else begin
                io.inst_raw = {16'h0, head.data};
            end
        end
    end

endmodule

// File: tb/tb_ifu_inst_align.sv
// Directed bench for ifu_inst_align: aligned, compressed, straddling,
// odd-start, backpressure, flush, mid-run reset and fetch-error cases.
module tb_ifu_inst_align;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ifu_inst_align_if bus ();

    ifu_inst_align #(
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one fetch word for exactly one edge; it must be accepted.
    task automatic send(input logic [31:0] pc_b, input logic [31:0] data, input logic err);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc_b[31:1];
        bus.fetch_data  = data;
        bus.fetch_err   = err;
        #1;
        check("send.ready", 32'(bus.fetch_ready), 32'd1);
        step();
        bus.fetch_valid = 1'b0;
        bus.fetch_err   = 1'b0;
        #1;
    endtask

    // The instruction must be presented now; it is retired at the next edge.
    task automatic expect_inst(input string tag, input logic [31:0] raw, input logic [31:0] pc_b,
                               input logic is_c, input logic err);
        logic [15:0] lo;
        lo = raw[15:0];
        check({tag, ".valid"}, 32'(bus.inst_valid), 32'd1);
        check({tag, ".raw"}, bus.inst_raw, raw);
        check({tag, ".pc"}, {bus.inst_pc, 1'b0}, pc_b);
        check({tag, ".is_c"}, 32'(bus.inst_is_c), 32'(is_c));
        check({tag, ".err"}, 32'(bus.inst_err), 32'(err));
        check({tag, ".c16"}, 32'(bus.inst_c16), 32'(lo));
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".fetch_ready"}, 32'(bus.fetch_ready), 32'd1);
        check({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'd0);
        check({tag, ".inst_raw"}, bus.inst_raw, 32'd0);
        check({tag, ".inst_pc"}, 32'(bus.inst_pc), 32'd0);
        check({tag, ".inst_c16"}, 32'(bus.inst_c16), 32'd0);
        check({tag, ".inst_is_c"}, 32'(bus.inst_is_c), 32'd0);
        check({tag, ".inst_err"}, 32'(bus.inst_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = 32'h0;
        bus.fetch_pc    = 31'h0;
        bus.fetch_err   = 1'b0;
        bus.inst_ready  = 1'b1;

        // Reset state
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();
        check_reset_outputs("post_rst");

        // Aligned 32-bit word
        send(32'h100, 32'h0010_0513, 1'b0);
        expect_inst("aligned", 32'h0010_0513, 32'h100, 1'b0, 1'b0);
        check("aligned.empty", 32'(bus.inst_valid), 32'd0);

        // Two compressed in one word, one per cycle
        send(32'h100, 32'h4505_0505, 1'b0);
        expect_inst("c0", 32'h0000_0505, 32'h100, 1'b1, 1'b0);
        expect_inst("c1", 32'h0000_4505, 32'h102, 1'b1, 1'b0);
        check("c.empty", 32'(bus.inst_valid), 32'd0);

        // Straddle: low half waits for the next word
        send(32'h200, 32'h0513_0001, 1'b0);
        expect_inst("st0", 32'h0000_0001, 32'h200, 1'b1, 1'b0);
        check("st.wait0", 32'(bus.inst_valid), 32'd0);
        step();
        check("st.wait1", 32'(bus.inst_valid), 32'd0);
        send(32'h204, 32'h0001_0010, 1'b0);
        expect_inst("st1", 32'h0010_0513, 32'h202, 1'b0, 1'b0);
        expect_inst("st2", 32'h0000_0001, 32'h206, 1'b1, 1'b0);
        check("st.empty", 32'(bus.inst_valid), 32'd0);

        // Odd start: parcel0 dropped
        send(32'h102, 32'h0001_FFFF, 1'b0);
        expect_inst("odd", 32'h0000_0001, 32'h102, 1'b1, 1'b0);
        check("odd.empty0", 32'(bus.inst_valid), 32'd0);
        step();
        check("odd.empty1", 32'(bus.inst_valid), 32'd0);

        // Backpressure fills the buffer
        bus.inst_ready = 1'b0;
        send(32'h500, 32'h0010_0513, 1'b0);
        send(32'h504, 32'h0020_0593, 1'b0);
        check("bp.full_ready", 32'(bus.fetch_ready), 32'd0);
        check("bp.valid", 32'(bus.inst_valid), 32'd1);
        step();
        check("bp.hold_raw", bus.inst_raw, 32'h0010_0513);
        check("bp.hold_pc", {bus.inst_pc, 1'b0}, 32'h500);
        bus.inst_ready = 1'b1;
        #1;
        expect_inst("bp0", 32'h0010_0513, 32'h500, 1'b0, 1'b0);
        expect_inst("bp1", 32'h0020_0593, 32'h504, 1'b0, 1'b0);
        check("bp.empty", 32'(bus.inst_valid), 32'd0);

        // Flush with a complete compressed plus a dangling low half buffered
        bus.inst_ready = 1'b0;
        send(32'h600, 32'h0513_0001, 1'b0);
        check("fl.pre_valid", 32'(bus.inst_valid), 32'd1);
        flush          = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        check("fl.valid", 32'(bus.inst_valid), 32'd0);
        check("fl.ready", 32'(bus.fetch_ready), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fl.empty", 32'(bus.inst_valid), 32'd0);
        send(32'h300, 32'h0000_0013, 1'b0);
        expect_inst("fl.new", 32'h0000_0013, 32'h300, 1'b0, 1'b0);
        check("fl.after", 32'(bus.inst_valid), 32'd0);

        // Reset mid-straddle
        send(32'h702, 32'h0513_0000, 1'b0);
        check("rr.wait", 32'(bus.inst_valid), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_outputs("rr");
        step();
        rst = 1'b0;
        step();
        send(32'h300, 32'h0000_0013, 1'b0);
        expect_inst("rr.new", 32'h0000_0013, 32'h300, 1'b0, 1'b0);

        // Fetch error: each parcel retires alone with err set
        send(32'h400, 32'h0010_0513, 1'b1);
        expect_inst("err0", 32'h0000_0513, 32'h400, 1'b0, 1'b1);
        expect_inst("err1", 32'h0000_0010, 32'h402, 1'b1, 1'b1);
        check("err.empty", 32'(bus.inst_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
